// File: rtl/logic_unit_pipe_if.sv
// Handshake bus for logic_unit_pipe: operand/opcode input channel and registered result channel.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             parity_flag;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, result, zero_flag, parity_flag, op_count
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, result, zero_flag, parity_flag, op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Single-stage registered bitwise logic unit with valid/ready flow control,
// zero/parity flags and a saturating count of completed output handshakes.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  logic_unit_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  op_e              op_sel;
  logic [WIDTH-1:0] op_out;
  logic             in_ready;
  logic             accept;
  logic             drain;

  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             parity_r;
  logic [CNT_W-1:0] count_r;

  assign op_sel = op_e'(bus.op);

  always_comb begin
    op_out = '0;
    case (op_sel)
      OP_AND:  op_out = bus.A & bus.B;
      OP_OR:   op_out = bus.A | bus.B;
      OP_NOT:  op_out = ~bus.A;
      OP_XOR:  op_out = bus.A ^ bus.B;
      OP_NAND: op_out = ~(bus.A & bus.B);
      OP_NOR:  op_out = ~(bus.A | bus.B);
      OP_XNOR: op_out = ~(bus.A ^ bus.B);
      OP_PASS: op_out = bus.B;
    endcase
  end

  // Ready depends only on the output side, so in_valid never loops back into in_ready.
  assign in_ready = ~out_valid_r | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;
  assign drain    = out_valid_r & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      zero_r      <= 1'b0;
      parity_r    <= 1'b0;
      count_r     <= '0;
    end else begin
      if (accept) begin
        out_valid_r <= 1'b1;
        result_r    <= op_out;
        zero_r      <= (op_out == '0);
        parity_r    <= ^op_out;
      end else if (drain) begin
        out_valid_r <= 1'b0;
      end
      if (drain && (count_r != '1)) begin
        count_r <= count_r + 1'b1;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_r;
  assign bus.result      = result_r;
  assign bus.zero_flag   = zero_r;
  assign bus.parity_flag = parity_r;
  assign bus.op_count    = count_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed cases plus random traffic against a queue-based reference model.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(2))  bus2 ();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of beats held in the stage, plus the last loaded result/flags.
  logic [7:0]  q[$];
  logic [7:0]  last_res;
  logic        last_zero;
  logic        last_par;
  int unsigned exp_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] calc(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return b;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    last_res  = 8'h00;
    last_zero = 1'b0;
    last_par  = 1'b0;
    exp_count = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check("result", 32'(bus.result), 32'(last_res));
    check("zero_flag", 32'(bus.zero_flag), 32'(last_zero));
    check("parity_flag", 32'(bus.parity_flag), 32'(last_par));
    check("op_count", 32'(bus.op_count), 32'(exp_count));
  endtask

  // One clock cycle: drive at negedge, check ready, update model at posedge, check after it.
  task automatic step(input logic v, input logic [2:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic rdy);
    logic       acc;
    logic       drn;
    logic [7:0] r;
    @(negedge clk);
    check_outputs();
    bus.in_valid  = v;
    bus.op        = o;
    bus.A         = a;
    bus.B         = b;
    bus.out_ready = rdy;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || rdy));
    acc = v && ((q.size() == 0) || rdy);
    drn = (q.size() != 0) && rdy;
    @(posedge clk);
    if (drn) begin
      void'(q.pop_front());
      if (exp_count < 65535) exp_count++;
    end
    if (acc) begin
      r = calc(o, a, b);
      q.push_back(r);
      last_res  = r;
      last_zero = (r == 8'h00);
      last_par  = (($countones(r) % 2) == 1);
    end
    #1;
    check("out_valid_post", 32'(bus.out_valid), 32'(q.size() != 0));
    check("op_count_post", 32'(bus.op_count), 32'(exp_count));
  endtask

  logic [7:0]  all_ops_exp [8];
  int unsigned sat_exp [5];
  int unsigned cnt_snap;

  initial begin
    all_ops_exp = '{8'h24, 8'hBD, 8'h5A, 8'h99, 8'hDB, 8'h42, 8'h66, 8'h3C};
    sat_exp     = '{1, 2, 3, 3, 3};

    bus.in_valid  = 1'b0; bus.out_ready = 1'b0;
    bus.A = 8'h00; bus.B = 8'h00; bus.op = 3'd0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    bus2.A = 8'h00; bus2.B = 8'h00; bus2.op = 3'd0;

    // Reset then idle
    #2 rst = 1'b1;
    #10;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_zero", 32'(bus.zero_flag), 32'd0);
    check("idle_parity", 32'(bus.parity_flag), 32'd0);

    // All ops, one beat each, consumer always ready
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 8'hA5, 8'h3C, 1'b1);
      check("allops_result", 32'(bus.result), 32'(all_ops_exp[i]));
      check("allops_parity", 32'(bus.parity_flag), 32'd0);
      check("allops_zero", 32'(bus.zero_flag), 32'd0);
    end
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    check("allops_count", 32'(bus.op_count), 32'd8);

    // Zero and parity flags
    step(1'b1, 3'd0, 8'hF0, 8'h0F, 1'b1);
    check("zp0_result", 32'(bus.result), 32'h00);
    check("zp0_zero", 32'(bus.zero_flag), 32'd1);
    check("zp0_parity", 32'(bus.parity_flag), 32'd0);
    step(1'b1, 3'd7, 8'h00, 8'h01, 1'b1);
    check("zp1_result", 32'(bus.result), 32'h01);
    check("zp1_zero", 32'(bus.zero_flag), 32'd0);
    check("zp1_parity", 32'(bus.parity_flag), 32'd1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

    // Backpressure with a waiting beat
    step(1'b1, 3'd3, 8'hFF, 8'h0F, 1'b1);
    check("bp_result", 32'(bus.result), 32'hF0);
    cnt_snap = exp_count;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd5, 8'h12, 8'h34, 1'b0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_result", 32'(bus.result), 32'hF0);
      check("bp_hold_count", 32'(bus.op_count), 32'(cnt_snap));
    end
    step(1'b1, 3'd5, 8'h12, 8'h34, 1'b1);
    check("bp_nobubble_valid", 32'(bus.out_valid), 32'd1);
    check("bp_new_result", 32'(bus.result), 32'hC9);
    check("bp_drain_count", 32'(bus.op_count), 32'(cnt_snap + 1));
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) != 0));
    end

    // Async reset in the middle of a stall
    step(1'b1, 3'd6, 8'h5A, 8'hC3, 1'b0);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_result", 32'(bus.result), 32'd0);
    check("arst_op_count", 32'(bus.op_count), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'd3, 8'h0F, 8'h33, 1'b1);
    check("post_rst_result", 32'(bus.result), 32'h3C);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

    // Counter saturation on the CNT_W=2 instance
    @(negedge clk);
    bus2.in_valid  = 1'b1;
    bus2.out_ready = 1'b1;
    bus2.op        = 3'd7;
    bus2.B         = 8'h01;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) check("sat_count", 32'(bus2.op_count), 32'(sat_exp[i-1]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
